// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: default widths,
// control-vector bit positions and the entry layout carried between stages.
package pipe_pkg;

  localparam int DATA_W  = 32;
  localparam int CTRL_W  = 5;
  localparam int RADDR_W = 5;

  localparam int CTRL_MEM_READ  = 0;
  localparam int CTRL_MEM_WRITE = 1;
  localparam int CTRL_MEM_REG   = 2;
  localparam int CTRL_REG_WRITE = 3;
  localparam int CTRL_ALU_ZERO  = 4;

  typedef struct packed {
    logic [DATA_W-1:0]  data0;
    logic [DATA_W-1:0]  data1;
    logic [CTRL_W-1:0]  ctrl;
    logic [RADDR_W-1:0] raddr;
  } stage_entry_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// One-entry holding register with valid flag; used as the skid buffer of
// pipe_stage_reg. Clear has priority over load.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter type entry_t = stage_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   clear,
  input  entry_t d,
  output entry_t q,
  output logic   valid
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      if (clear)     valid <= 1'b0;
      else if (load) valid <= 1'b1;
      if (load) q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush
// and bubble-masked control. Macro PIPE_STAGE_SKID_EN adds a one-entry skid
// buffer and registers in_ready; otherwise in_ready is ~out_valid | out_ready.
module pipe_stage_reg #(
  parameter int DATA_W  = pipe_pkg::DATA_W,
  parameter int CTRL_W  = pipe_pkg::CTRL_W,
  parameter int RADDR_W = pipe_pkg::RADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data0,
  input  logic [DATA_W-1:0]  in_data1,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [RADDR_W-1:0] in_raddr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data0,
  output logic [DATA_W-1:0]  out_data1,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [RADDR_W-1:0] out_raddr
);

  typedef struct packed {
    logic [DATA_W-1:0]  data0;
    logic [DATA_W-1:0]  data1;
    logic [CTRL_W-1:0]  ctrl;
    logic [RADDR_W-1:0] raddr;
  } entry_t;

  entry_t in_entry;
  entry_t out_q;
  entry_t src;
  logic   out_valid_q;
  logic   drain;
  logic   accept;
  logic   src_valid;

  assign in_entry = '{data0: in_data0, data1: in_data1, ctrl: in_ctrl, raddr: in_raddr};
  assign drain    = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
  entry_t skid_q;
  logic   skid_valid;
  logic   skid_load;
  logic   skid_clear;
  logic   skid_valid_nxt;

  // Skid only captures when the output is stalled; it empties into the output first.
  assign skid_load  = accept & ~drain & ~flush;
  assign skid_clear = flush | (drain & skid_valid);

  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    skid_valid_nxt = skid_valid;
    if (skid_clear)     skid_valid_nxt = 1'b0;
    else if (skid_load) skid_valid_nxt = 1'b1;
  end

  pipe_skid_slot #(.entry_t(entry_t)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_entry),
    .q     (skid_q),
    .valid (skid_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_ready <= 1'b1;
    else     in_ready <= ~skid_valid_nxt;
  end

  assign src       = skid_valid ? skid_q : in_entry;
  assign src_valid = skid_valid | accept;
`else
  assign in_ready  = drain;
  assign src       = in_entry;
  assign src_valid = accept;
`endif

  // NOTE: payload flops are reset along with the valid bit so the outputs read
  // zero straight out of reset; flush clears only the valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      if (flush)      out_valid_q <= 1'b0;
      else if (drain) out_valid_q <= src_valid;
      if (drain && src_valid) out_q <= src;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data0 = out_q.data0;
  assign out_data1 = out_q.data1;
  assign out_raddr = out_q.raddr;
  // A bubble must never carry write enables downstream.
  assign out_ctrl  = out_q.ctrl & {CTRL_W{out_valid_q}};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg; handles both PIPE_STAGE_SKID_EN settings.
// Reference model: an in-order queue with capacity 1 (no skid) or 2 (skid).
`timescale 1ns/1ps
module tb_pipe_stage_reg;
  import pipe_pkg::*;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data0;
  logic [DATA_W-1:0]  in_data1;
  logic [CTRL_W-1:0]  in_ctrl;
  logic [RADDR_W-1:0] in_raddr;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data0;
  logic [DATA_W-1:0]  out_data1;
  logic [CTRL_W-1:0]  out_ctrl;
  logic [RADDR_W-1:0] out_raddr;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_ctrl   (in_ctrl),
    .in_raddr  (in_raddr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_ctrl  (out_ctrl),
    .out_raddr (out_raddr)
  );

  int total = 0;
  int bad   = 0;
  stage_entry_t mq[$];
  stage_entry_t cur_in;

  function automatic stage_entry_t mk(input logic [31:0] d);
    stage_entry_t e;
    e.data0 = d;
    e.data1 = ~d;
    e.ctrl  = d[4:0];
    e.raddr = d[4:0] ^ 5'h1f;
    return e;
  endfunction

  function automatic stage_entry_t rnd_entry();
    stage_entry_t e;
    e.data0 = $urandom;
    e.data1 = $urandom;
    e.ctrl  = 5'($urandom);
    e.raddr = 5'($urandom);
    return e;
  endfunction

  // Stage accepts when it has free capacity, or (no skid) when its one entry leaves now.
  function automatic bit model_ready(input bit ordy);
    if (SKID) return mq.size() < 2;
    return (mq.size() == 0) || ordy;
  endfunction

  task automatic drive(input bit v, input bit r, input bit f, input stage_entry_t e);
    in_valid  = v;
    out_ready = r;
    flush     = f;
    cur_in    = e;
    in_data0  = e.data0;
    in_data1  = e.data1;
    in_ctrl   = e.ctrl;
    in_raddr  = e.raddr;
  endtask

  // Clock one edge and apply the same transfers to the model queue.
  task automatic advance();
    bit acc;
    bit pop;
    acc = in_valid && model_ready(out_ready);
    pop = (mq.size() > 0) && out_ready;
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (flush)    mq.delete();
    else if (acc) mq.push_back(cur_in);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0);
    #1;
    total++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data0 !== '0) begin
      bad++;
      $display("FAIL reset_initial: valid=%b ctrl=%b data0=%h, expected 0/0/0", out_valid, out_ctrl, out_data0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: in_ready=%b, expected 1", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, mk(32'h50 + i));
      advance();
    end
    total++;
    if (out_valid !== 1'b1 || out_data0 !== 32'h52) begin
      bad++;
      $display("FAIL reset_prestream: valid=%b data0=%h, expected 1/00000052", out_valid, out_data0);
    end
    drive(1'b1, 1'b0, 1'b0, mk(32'h53));
    #2;
    rst = 1'b1;
    #1;
    mq.delete();
    total++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data0 !== '0) begin
      bad++;
      $display("FAIL reset_async: valid=%b ctrl=%b data0=%h, expected 0/0/0", out_valid, out_ctrl, out_data0);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, '0);
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: in_ready=%b valid=%b, expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_stream();
    stage_entry_t e;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stream_empty: valid=%b, expected 0", out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      e = rnd_entry();
      e.data0 = i;
      drive(1'b1, 1'b1, 1'b0, e);
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL stream_ready[%0d]: in_ready=%b, expected 1", i, in_ready);
      end
      advance();
      total++;
      if (out_valid !== 1'b1 || out_data0 !== e.data0 || out_data1 !== e.data1 ||
          out_ctrl !== e.ctrl || out_raddr !== e.raddr) begin
        bad++;
        $display("FAIL stream_out[%0d]: valid=%b data0=%h ctrl=%b, expected 1/%h/%b", i, out_valid, out_data0, out_ctrl, e.data0, e.ctrl);
      end
    end
    drive(1'b0, 1'b1, 1'b0, '0);
    advance();
    total++;
    if (out_valid !== 1'b0 || out_ctrl !== '0) begin
      bad++;
      $display("FAIL stream_tail: valid=%b ctrl=%b, expected 0/00000", out_valid, out_ctrl);
    end
  endtask

  task automatic test_stall();
    int next_d;
    bit present;
    bit acc;
    bit exp_rdy;
    stage_entry_t held;
    int got[$];
    held = mk(32'd100);
    drive(1'b1, 1'b1, 1'b0, held);
    advance();
    next_d = 101;
    for (int k = 0; k < 3; k++) begin
      present = (next_d <= 103);
      drive(present, 1'b0, 1'b0, mk(next_d));
      #1;
      exp_rdy = SKID && (k == 0);
      total++;
      if (in_ready !== exp_rdy) begin
        bad++;
        $display("FAIL stall_ready[%0d]: in_ready=%b, expected %b", k, in_ready, exp_rdy);
      end
      acc = present && model_ready(1'b0);
      advance();
      if (acc) next_d++;
      total++;
      if (out_valid !== 1'b1 || out_data0 !== held.data0 || out_data1 !== held.data1 ||
          out_ctrl !== held.ctrl || out_raddr !== held.raddr) begin
        bad++;
        $display("FAIL stall_hold[%0d]: valid=%b data0=%h ctrl=%b, expected 1/%h/%b", k, out_valid, out_data0, out_ctrl, held.data0, held.ctrl);
      end
    end
    for (int n = 0; n < 20; n++) begin
      present = (next_d <= 103);
      drive(present, 1'b1, 1'b0, mk(next_d));
      #1;
      if (out_valid === 1'b1) got.push_back(int'(out_data0));
      else if (!present) break;
      acc = present && model_ready(1'b1);
      advance();
      if (acc) next_d++;
    end
    total++;
    if (got.size() != 4) begin
      bad++;
      $display("FAIL stall_count: drained %0d entries, expected 4", got.size());
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      total++;
      if (got[i] != 100 + i) begin
        bad++;
        $display("FAIL stall_order[%0d]: data0=%0d, expected %0d", i, got[i], 100 + i);
      end
    end
  endtask

  task automatic test_flush();
    stage_entry_t k;
    k = mk(32'hF1);
    k.ctrl = '0;
    k.ctrl[CTRL_REG_WRITE] = 1'b1;
    drive(1'b1, 1'b1, 1'b0, mk(32'h200));
    advance();
    drive(1'b1, 1'b1, 1'b1, k);
    advance();
    total++;
    if (out_valid !== 1'b0 || out_ctrl !== '0) begin
      bad++;
      $display("FAIL flush_kill: valid=%b ctrl=%b, expected 0/00000", out_valid, out_ctrl);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      advance();
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL flush_gone[%0d]: valid=%b data0=%h, expected valid 0", i, out_valid, out_data0);
      end
    end
    drive(1'b1, 1'b0, 1'b0, mk(32'h300));
    advance();
    drive(1'b1, 1'b0, 1'b0, mk(32'h301));
    advance();
    drive(1'b1, 1'b0, 1'b1, mk(32'h302));
    advance();
    drive(1'b0, 1'b0, 1'b0, '0);
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_full: valid=%b in_ready=%b, expected 0/1", out_valid, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      advance();
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL flush_full_gone[%0d]: valid=%b data0=%h, expected valid 0", i, out_valid, out_data0);
      end
    end
  endtask

  task automatic test_bubble();
    stage_entry_t e;
    for (int i = 0; i < 4; i++) begin
      e = rnd_entry();
      e.ctrl = 5'b11111;
      drive(1'b0, 1'($urandom), 1'b0, e);
      advance();
      total++;
      if (out_valid !== 1'b0 || out_ctrl !== 5'b00000) begin
        bad++;
        $display("FAIL bubble[%0d]: valid=%b ctrl=%b, expected 0/00000", i, out_valid, out_ctrl);
      end
    end
  endtask

  task automatic test_random();
    bit v;
    bit r;
    bit f;
    bit exp_rdy;
    for (int c = 0; c < 10000; c++) begin
      v = ($urandom_range(99) < 70);
      r = ($urandom_range(99) < 60);
      f = ($urandom_range(99) < 3);
      drive(v, r, f, rnd_entry());
      #1;
      exp_rdy = model_ready(r);
      total++;
      if (in_ready !== exp_rdy) begin
        bad++;
        $display("FAIL rand_ready@%0d: in_ready=%b, expected %b", c, in_ready, exp_rdy);
      end
      total++;
      if (out_valid !== (mq.size() > 0)) begin
        bad++;
        $display("FAIL rand_valid@%0d: valid=%b, expected %b", c, out_valid, mq.size() > 0);
      end
      total++;
      if (mq.size() > 0) begin
        if (out_data0 !== mq[0].data0 || out_data1 !== mq[0].data1 ||
            out_ctrl !== mq[0].ctrl || out_raddr !== mq[0].raddr) begin
          bad++;
          $display("FAIL rand_data@%0d: data0=%h ctrl=%b raddr=%h, expected %h/%b/%h", c, out_data0, out_ctrl, out_raddr, mq[0].data0, mq[0].ctrl, mq[0].raddr);
        end
      end else if (out_ctrl !== '0) begin
        bad++;
        $display("FAIL rand_bubble@%0d: ctrl=%b, expected 00000", c, out_ctrl);
      end
      advance();
    end
    for (int n = 0; n < 4 && mq.size() > 0; n++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      advance();
    end
    total++;
    if (out_valid !== 1'b0 || mq.size() != 0) begin
      bad++;
      $display("FAIL rand_drain: valid=%b model=%0d, expected 0/0", out_valid, mq.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_bubble();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
